shift_sequencer: RTL and testbench

Command-driven controller that owns a WIDTH-bit universal shift register and sequences it: parallel load, then N shift cycles left or right, then hold. It accepts one command per valid/ready handshake, drives the per-bit select code (00 hold, 01 shift left, 10 shift right, 11 parallel load), and streams serial data in and out. It sits between a command source (bus slave or test FSM) and serial links that need framed, length-controlled shifting.

---
 rtl/shift_sequencer_pkg.sv | 23 ++
 rtl/shift_reg_nbit.sv | 30 +++
 rtl/shift_sequencer.sv | 118 +++++++++++
 tb/tb_shift_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared select codes, directions and FSM states for shift_sequencer
package shift_sequencer_pkg;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_LEFT  = 2'b01;
    localparam logic [1:0] SEL_RIGHT = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [1:0] shift_sel(input logic dir);
        return (dir == DIR_LEFT) ? SEL_LEFT : SEL_RIGHT;
    endfunction

endpackage

// File: rtl/shift_reg_nbit.sv
// rtl/shift_reg_nbit.sv - WIDTH-bit universal register: hold, shift left, shift right, parallel load
module shift_reg_nbit
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_in_left,
    input  logic             ser_in_right,
    output logic [WIDTH-1:0] q
);

    // ser_in_left enters at the MSB end (right shift), ser_in_right at the LSB end (left shift)
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            q <= '0;
        end else begin
            case (sel)
                SEL_LEFT:  q <= {q[WIDTH-2:0], ser_in_right};
                SEL_RIGHT: q <= {ser_in_left, q[WIDTH-1:1]};
                SEL_LOAD:  q <= par_in;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - command-driven load/shift/hold sequencer; optional rotate via SHIFT_SEQUENCER_ROTATE_EN
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] load_data,
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    input  logic             cmd_rot,
`endif
    input  logic             ser_in,
    output logic             ser_out,
    output logic [WIDTH-1:0] q,
    output logic [1:0]       sel_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_l;
    logic [CNT_W-1:0] len_eff;
    logic             dir_l;
    logic [WIDTH-1:0] data_l;
    logic             enter_bit;

    assign len_eff = (cmd_len > WIDTH_CNT) ? WIDTH_CNT : cmd_len;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            len_l  <= '0;
            dir_l  <= DIR_RIGHT;
            data_l <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        len_l  <= len_eff;
                        dir_l  <= cmd_dir;
                        data_l <= load_data;
                    end
                end
                S_LOAD:  cnt <= len_l;
                S_SHIFT: cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        sel_out   = SEL_HOLD;
        case (state)
            S_IDLE: begin
                if (cmd_valid) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                sel_out   = SEL_LOAD;
                state_nxt = (len_l != '0) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                sel_out = shift_sel(dir_l);
                if (cnt <= CNT_W'(1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign ser_out   = (dir_l == DIR_LEFT) ? q[WIDTH-1] : q[0];

`ifdef SHIFT_SEQUENCER_ROTATE_EN
    logic rot_l;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            rot_l <= 1'b0;
        end else if (state == S_IDLE && cmd_valid) begin
            rot_l <= cmd_rot;
        end
    end

    // Rotating feeds the departing bit straight back into the vacated end
    assign enter_bit = rot_l ? ser_out : ser_in;
`else
    assign enter_bit = ser_in;
`endif

    shift_reg_nbit #(
        .WIDTH(WIDTH)
    ) u_reg (
        .clk          (clk),
        .sync_reset   (sync_reset),
        .sel          (sel_out),
        .par_in       (data_l),
        .ser_in_left  (enter_bit),
        .ser_in_right (enter_bit),
        .q            (q)
    );

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer
module tb_shift_sequencer;
    import shift_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       sync_reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [3:0] cmd_len;
    logic [7:0] load_data;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    logic       cmd_rot;
`endif
    logic       ser_in;
    logic       ser_out;
    logic [7:0] q;
    logic [1:0] sel_out;
    logic       busy;
    logic       done;

    shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_len    (cmd_len),
        .load_data  (load_data),
`ifdef SHIFT_SEQUENCER_ROTATE_EN
        .cmd_rot    (cmd_rot),
`endif
        .ser_in     (ser_in),
        .ser_out    (ser_out),
        .q          (q),
        .sel_out    (sel_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic       ser;
        bit         chk_ser;
    } trace_t;

    typedef struct {
        logic [7:0] q;
        int         lat;
        string      name;
    } result_t;

    trace_t  trace_q[$];
    result_t result_q[$];
    trace_t  mon_t;
    result_t mon_r;

    int n_pass = 0;
    int n_chk = 0;
    int cycle = 0;
    int accept_cyc = 0;
    bit trace_en = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pops expected per-cycle trace while busy and expected result on each done
    always @(negedge clk) begin
        if (!sync_reset) begin
            if (cmd_valid && cmd_ready) accept_cyc = cycle + 1;
            if (busy && trace_en) begin
                check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
                if (trace_q.size() == 0) begin
                    check("trace_underflow", 32'd1, 32'd0);
                end else begin
                    mon_t = trace_q.pop_front();
                    check("sel_out", 32'(sel_out), 32'(mon_t.sel));
                    if (mon_t.chk_ser) check("ser_out", 32'(ser_out), 32'(mon_t.ser));
                end
            end
            if (done) begin
                if (result_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_r = result_q.pop_front();
                    check({mon_r.name, "_q"}, 32'(q), 32'(mon_r.q));
                    check({mon_r.name, "_latency"}, 32'(cycle - accept_cyc + 1), 32'(mon_r.lat));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_trace(input logic [1:0] sel, input logic ser, input bit chk);
        trace_t t;
        t.sel = sel;
        t.ser = ser;
        t.chk_ser = chk;
        trace_q.push_back(t);
    endtask

    task automatic push_result(input logic [7:0] qv, input int lat, input string name);
        result_t r;
        r.q = qv;
        r.lat = lat;
        r.name = name;
        result_q.push_back(r);
    endtask

    // Presents a command for exactly the accept edge, then scrambles the inputs
    task automatic issue(input logic dir, input logic [3:0] len, input logic [7:0] data);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_len   = len;
        load_data = data;
        tick();
        cmd_valid = 1'b0;
        cmd_dir   = ~dir;
        cmd_len   = 4'd0;
        load_data = ~data;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) check("busy_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        logic [7:0] v;
        int n;

        sync_reset = 1'b1;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_len    = 4'd0;
        load_data  = 8'h00;
        ser_in     = 1'b0;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
        cmd_rot    = 1'b0;
`endif
        tick();
        tick();
        check("reset_q", 32'(q), 32'h0);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sel_out", 32'(sel_out), 32'(SEL_HOLD));
        check("reset_ser_out", 32'(ser_out), 32'd0);
        sync_reset = 1'b0;
        trace_en = 1'b1;
        tick();

        // Right shift A5 by 4 with ser_in=1
        ser_in = 1'b1;
        push_trace(SEL_LOAD, 1'b0, 1'b0);
        push_trace(SEL_RIGHT, 1'b1, 1'b1);
        push_trace(SEL_RIGHT, 1'b0, 1'b1);
        push_trace(SEL_RIGHT, 1'b1, 1'b1);
        push_trace(SEL_RIGHT, 1'b0, 1'b1);
        push_trace(SEL_HOLD, 1'b0, 1'b1);
        push_result(8'hFA, 6, "right");
        issue(DIR_RIGHT, 4'd4, 8'hA5);
        wait_idle();

        // Left shift 81 by 3 with ser_in=0
        ser_in = 1'b0;
        push_trace(SEL_LOAD, 1'b0, 1'b0);
        push_trace(SEL_LEFT, 1'b1, 1'b1);
        push_trace(SEL_LEFT, 1'b0, 1'b1);
        push_trace(SEL_LEFT, 1'b0, 1'b1);
        push_trace(SEL_HOLD, 1'b0, 1'b1);
        push_result(8'h08, 5, "left");
        issue(DIR_LEFT, 4'd3, 8'h81);
        wait_idle();

        // Zero length: load then done
        push_trace(SEL_LOAD, 1'b0, 1'b0);
        push_trace(SEL_HOLD, 1'b0, 1'b1);
        push_result(8'h5A, 2, "len0");
        issue(DIR_RIGHT, 4'd0, 8'h5A);
        wait_idle();

        // Length 15 clamps to 8: full flush with ones
        ser_in = 1'b1;
        v = 8'h3C;
        push_trace(SEL_LOAD, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) push_trace(SEL_RIGHT, v[i], 1'b1);
        push_trace(SEL_HOLD, 1'b1, 1'b1);
        push_result(8'hFF, 10, "clamp");
        issue(DIR_RIGHT, 4'd15, 8'h3C);
        wait_idle();

        // Back-to-back with cmd_valid held high
        ser_in = 1'b0;
        push_trace(SEL_LOAD, 1'b0, 1'b0);
        push_trace(SEL_RIGHT, 1'b0, 1'b1);
        push_trace(SEL_RIGHT, 1'b0, 1'b1);
        push_trace(SEL_HOLD, 1'b1, 1'b1);
        push_trace(SEL_LOAD, 1'b0, 1'b0);
        push_trace(SEL_LEFT, 1'b1, 1'b1);
        push_trace(SEL_HOLD, 1'b0, 1'b1);
        push_result(8'h0F, 4, "b2b_first");
        push_result(8'h2C, 3, "b2b_second");
        cmd_valid = 1'b1;
        cmd_dir   = DIR_RIGHT;
        cmd_len   = 4'd2;
        load_data = 8'h3C;
        tick();
        cmd_dir   = DIR_LEFT;
        cmd_len   = 4'd1;
        load_data = 8'h96;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("b2b_done_seen", 32'(done), 32'd1);
        check("b2b_ready_in_done", 32'(cmd_ready), 32'd0);
        tick();
        check("b2b_ready_idle", 32'(cmd_ready), 32'd1);
        check("b2b_busy_idle", 32'(busy), 32'd0);
        tick();
        check("b2b_busy_second", 32'(busy), 32'd1);
        cmd_valid = 1'b0;
        load_data = 8'h00;
        wait_idle();

`ifdef SHIFT_SEQUENCER_ROTATE_EN
        // Rotate ignores ser_in
        ser_in  = 1'b0;
        cmd_rot = 1'b1;
        push_trace(SEL_LOAD, 1'b0, 1'b0);
        push_trace(SEL_RIGHT, 1'b1, 1'b1);
        push_trace(SEL_HOLD, 1'b0, 1'b1);
        push_result(8'h80, 3, "rot1");
        issue(DIR_RIGHT, 4'd1, 8'h01);
        wait_idle();
        v = 8'h01;
        push_trace(SEL_LOAD, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) push_trace(SEL_RIGHT, v[i], 1'b1);
        push_trace(SEL_HOLD, 1'b1, 1'b1);
        push_result(8'h01, 10, "rot8");
        issue(DIR_RIGHT, 4'd8, 8'h01);
        wait_idle();
        cmd_rot = 1'b0;
`endif

        // Reset in the third shift cycle abandons the command
        trace_en = 1'b0;
        ser_in = 1'b0;
        issue(DIR_RIGHT, 4'd8, 8'hA5);
        tick();
        tick();
        tick();
        check("midshift_busy", 32'(busy), 32'd1);
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        check("midreset_q", 32'(q), 32'h0);
        check("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_sel_out", 32'(sel_out), 32'(SEL_HOLD));
        for (int i = 0; i < 10; i++) tick();

        check("trace_queue_empty", 32'(trace_q.size()), 32'd0);
        check("result_queue_empty", 32'(result_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
